// File: rtl/mem_arbiter.sv
// Four-core round-robin initiator for the shared data RAM port.
// One transaction in flight at a time: IDLE (grant) -> ACCESS (RAM cycle) -> RESP (ready pulse).

module mem_arb_lane #(
  parameter int IDX   = 0,
  parameter int PTR_W = 2
) (
  input  logic             req,
  input  logic [PTR_W-1:0] rr_ptr,
  input  logic             rsp_vld,
  input  logic [PTR_W-1:0] gnt_id,
  output logic             req_hi,
  output logic             ready
);
  // Requests at or above the pointer win before any wrapped-around request.
  assign req_hi = req && (PTR_W'(IDX) >= rr_ptr);
  assign ready  = rsp_vld && (gnt_id == PTR_W'(IDX));
endmodule

module mem_arbiter #(
  parameter int N_CORES = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_CORES-1:0]        core_req,
  input  logic [N_CORES-1:0]        core_we,
  input  logic [N_CORES*ADDR_W-1:0] core_addr,
  input  logic [N_CORES*DATA_W-1:0] core_wdata,
  output logic [N_CORES-1:0]        core_ready,
  output logic [DATA_W-1:0]         core_rdata,
  output logic                      ram_we,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [DATA_W-1:0]         ram_wdata,
  input  logic [DATA_W-1:0]         ram_rdata,
  output logic                      busy
);
  localparam int PTR_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } txn_t;

  state_t                   state;
  logic [PTR_W-1:0]         rr_ptr;
  logic [PTR_W-1:0]         gnt_id;
  logic [PTR_W-1:0]         pick_id;
  txn_t                     txn;
  logic [DATA_W-1:0]        rdata_q;
  logic                     rsp_vld;
  logic [N_CORES-1:0]       req_hi;
  txn_t [N_CORES-1:0]       cand;

  for (genvar i = 0; i < N_CORES; i++) begin : g_lane
    assign cand[i] = {core_we[i], core_addr[i*ADDR_W +: ADDR_W], core_wdata[i*DATA_W +: DATA_W]};

    mem_arb_lane #(.IDX(i), .PTR_W(PTR_W)) u_lane (
      .req     (core_req[i]),
      .rr_ptr  (rr_ptr),
      .rsp_vld (rsp_vld),
      .gnt_id  (gnt_id),
      .req_hi  (req_hi[i]),
      .ready   (core_ready[i])
    );
  end

  // Lowest requester overall, overridden by the lowest one at/above rr_ptr if any.
  always_comb begin
    pick_id = '0;
    for (int i = N_CORES-1; i >= 0; i--)
      if (core_req[i]) pick_id = PTR_W'(i);
    for (int i = N_CORES-1; i >= 0; i--)
      if (req_hi[i]) pick_id = PTR_W'(i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      gnt_id  <= '0;
      txn     <= '0;
      rdata_q <= '0;
      rsp_vld <= 1'b0;
      ram_we  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|core_req) begin
            gnt_id <= pick_id;
            txn    <= cand[pick_id];
            ram_we <= cand[pick_id].we;
            busy   <= 1'b1;
            state  <= ACCESS;
          end
        end
        ACCESS: begin
          rdata_q <= ram_rdata;
          rr_ptr  <= (gnt_id == PTR_W'(N_CORES-1)) ? '0 : gnt_id + PTR_W'(1);
          ram_we  <= 1'b0;
          rsp_vld <= 1'b1;
          state   <= RESP;
        end
        RESP: begin
          rsp_vld <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ram_addr   = txn.addr;
  assign ram_wdata  = txn.wdata;
  assign core_rdata = rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios then random traffic, checked against a
// transaction-level schedule model (grant -> RAM cycle +1 -> ready +2, next grant +3).

module tb_mem_arbiter;
  localparam int N = 4;
  localparam int MAXC = 4096;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0]       core_req, core_we, core_ready;
  logic [N-1:0][31:0] c_addr, c_wdata;
  logic [N*32-1:0]    core_addr, core_wdata;
  logic [31:0]        core_rdata, ram_addr, ram_wdata, ram_rdata;
  logic               ram_we, busy;

  assign core_addr  = c_addr;
  assign core_wdata = c_wdata;

  mem_arbiter #(.N_CORES(N), .ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .core_req   (core_req),
    .core_we    (core_we),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_ready (core_ready),
    .core_rdata (core_rdata),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .busy       (busy)
  );

  // 1 KB RAM with combinational read, written on the rising edge
  logic [31:0] mem [256];
  logic        mem_clr;
  assign ram_rdata = mem[ram_addr[9:2]];
  always @(posedge clk)
    if (mem_clr) for (int i = 0; i < 256; i++) mem[i] <= '0;
    else if (ram_we) mem[ram_addr[9:2]] <= ram_wdata;

  // Reference model: expected outputs scheduled per cycle
  logic [31:0] ref_mem [256];
  logic [3:0]  x_rdy  [MAXC];
  logic        x_we   [MAXC];
  logic        x_busy [MAXC];
  logic [31:0] x_addr [MAXC];
  logic [31:0] x_wd   [MAXC];
  logic [31:0] x_rd   [MAXC];
  int          cyc_n, free_at, ptr, n_chk, n_fail;
  logic [N-1:0] keep;
  logic [3:0]  prev_rdy;
  int          obs_gnt [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear(input int from);
    for (int i = from; i < MAXC; i++) begin
      x_rdy[i] = '0; x_we[i] = 1'b0; x_busy[i] = 1'b0;
      x_addr[i] = '0; x_wd[i] = '0; x_rd[i] = '0;
    end
  endtask

  task automatic cyc();
    int id;
    if (x_we[cyc_n]) ref_mem[x_addr[cyc_n][9:2]] = x_wd[cyc_n];
    if (cyc_n >= free_at && |core_req) begin
      id = -1;
      for (int k = 0; k < N; k++)
        if (id < 0 && core_req[(ptr+k)%N]) id = (ptr+k)%N;
      x_we[cyc_n+1]   = core_we[id];
      x_addr[cyc_n+1] = c_addr[id];
      x_wd[cyc_n+1]   = c_wdata[id];
      x_busy[cyc_n+1] = 1'b1;
      x_rdy[cyc_n+2]  = 4'(1 << id);
      x_rd[cyc_n+2]   = ref_mem[c_addr[id][9:2]];
      x_busy[cyc_n+2] = 1'b1;
      free_at = cyc_n + 3;
      ptr = (id + 1) % N;
    end
    @(posedge clk);
    cyc_n++;
    @(negedge clk);
    chk("core_ready", core_ready, x_rdy[cyc_n]);
    chk("ram_we", ram_we, x_we[cyc_n]);
    chk("busy", busy, x_busy[cyc_n]);
    if (x_we[cyc_n] || x_busy[cyc_n] && x_rdy[cyc_n] == 0) begin
      chk("ram_addr", ram_addr, x_addr[cyc_n]);
      if (x_we[cyc_n]) chk("ram_wdata", ram_wdata, x_wd[cyc_n]);
    end
    if (x_rdy[cyc_n] != 0) begin
      chk("core_rdata", core_rdata, x_rd[cyc_n]);
      for (int i = 0; i < N; i++) if (core_ready[i]) obs_gnt.push_back(i);
    end
    chk("ready_onehot", 32'($onehot0(core_ready)), 1);
    chk("ready_consec", core_ready & prev_rdy, 0);
    prev_rdy = core_ready;
    for (int i = 0; i < N; i++)
      if (x_rdy[cyc_n][i] && !keep[i]) core_req[i] = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    core_req = '0;
    model_clear(cyc_n);
    free_at = cyc_n;
    ptr = 0;
    repeat (n) begin
      @(posedge clk);
      cyc_n++;
      @(negedge clk);
      chk("rst_ready", core_ready, 0);
      chk("rst_we", ram_we, 0);
      chk("rst_busy", busy, 0);
      chk("rst_addr", ram_addr, 0);
      chk("rst_wdata", ram_wdata, 0);
      chk("rst_rdata", core_rdata, 0);
    end
    rst_n = 1'b1;
    prev_rdy = '0;
  endtask

  task automatic set_core(input int i, input logic we, input logic [31:0] a, input logic [31:0] d);
    core_we[i] = we;
    c_addr[i]  = a;
    c_wdata[i] = d;
    core_req[i] = 1'b1;
  endtask

  initial begin
    n_chk = 0; n_fail = 0; cyc_n = 0; free_at = 0; ptr = 0;
    keep = '0; prev_rdy = '0;
    core_req = '0; core_we = '0; c_addr = '0; c_wdata = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    model_clear(0);
    mem_clr = 1'b1;
    rst_n = 1'b0;
    do_reset(2);
    mem_clr = 1'b0;

    // single store from core 2
    set_core(2, 1'b1, 32'h10, 32'hDEADBEEF);
    run(1);
    chk("t1_we", ram_we, 1);
    chk("t1_addr", ram_addr, 32'h10);
    run(1);
    chk("t1_ready", core_ready, 4'b0100);
    run(1);
    chk("t1_we_off", ram_we, 0);
    chk("t1_mem", mem[4], 32'hDEADBEEF);

    // store then load from core 1
    set_core(1, 1'b1, 32'h40, 32'h12345678);
    run(3);
    set_core(1, 1'b0, 32'h40, 32'h0);
    run(2);
    chk("t2_ready", core_ready, 4'b0010);
    chk("t2_rdata", core_rdata, 32'h12345678);
    run(1);

    // full contention from reset
    do_reset(2);
    keep = '1;
    for (int i = 0; i < N; i++) set_core(i, 1'b0, 32'({i[5:0], 2'b00}), 32'h0);
    obs_gnt.delete();
    run(15);
    keep = '0;
    run(15);
    core_req = '0;
    run(2);
    chk("cont_cnt", 32'(obs_gnt.size() >= 5), 1);
    chk("cont_g0", obs_gnt[0], 0);
    chk("cont_g1", obs_gnt[1], 1);
    chk("cont_g2", obs_gnt[2], 2);
    chk("cont_g3", obs_gnt[3], 3);
    chk("cont_g4", obs_gnt[4], 0);

    // pointer wrap after a grant to core 3
    set_core(3, 1'b1, 32'h20, 32'h33333333);
    run(3);
    set_core(0, 1'b0, 32'h20, 32'h0);
    set_core(3, 1'b0, 32'h10, 32'h0);
    obs_gnt.delete();
    run(6);
    chk("wrap_first", obs_gnt[0], 0);
    chk("wrap_second", obs_gnt[1], 3);

    // core 0 drops its request during ACCESS
    set_core(0, 1'b1, 32'h80, 32'hA5A50001);
    run(1);
    core_req[0] = 1'b0;
    run(1);
    chk("drop_ready", core_ready, 4'b0001);
    run(1);
    chk("drop_mem", mem[32], 32'hA5A50001);

    // reset in the middle of a store's ACCESS cycle
    set_core(1, 1'b1, 32'h80, 32'hBAD0BAD0);
    run(1);
    chk("abort_we_pre", ram_we, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_we", ram_we, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ready", core_ready, 0);
    chk("abort_addr", ram_addr, 0);
    do_reset(2);
    chk("abort_mem", mem[32], 32'hA5A50001);
    chk("abort_ref", mem[32], ref_mem[32]);
    set_core(0, 1'b0, 32'h80, 32'h0);
    set_core(2, 1'b0, 32'h10, 32'h0);
    obs_gnt.delete();
    run(6);
    chk("abort_first", obs_gnt[0], 0);
    chk("abort_rdata_seen", 32'(obs_gnt.size()), 2);

    // random traffic over a small address window to hit store/load overlaps
    for (int t = 0; t < 600; t++) begin
      for (int i = 0; i < N; i++)
        if (!core_req[i] && $urandom_range(0, 2) == 0)
          set_core(i, 1'($urandom_range(0, 1)), {26'd0, 4'($urandom_range(0, 15)), 2'b00}, $urandom);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
